branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter `PC_W`, default 32, PC and target width.
REQ-002 SHALL have port `clk`, input, 1 bit: clock; all state rises on posedge.
REQ-003 SHALL have port `reset_i`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `valid_f_i`, input, 1 bit: fetch slot holds an instruction.
REQ-005 SHALL have port `pc_f_i`, input, PC_W: fetch PC.
REQ-006 SHALL have port `pred_taken_f_i`, input, 1 bit: fetch-stage taken prediction (BTB hit AND predictor taken).
REQ-007 SHALL have port `pred_target_f_i`, input, PC_W: BTB target supplied with the prediction.
REQ-008 SHALL have port `btb_hit_f_i`, input, 1 bit: BTB tag hit at fetch.
REQ-009 SHALL have port `stall_i`, input, 1 bit: freezes the F->D and D->E stage registers.
REQ-010 SHALL have ports `is_branch_e_i` and `is_jump_e_i`, input, 1 bit each: execute-stage instruction class.
REQ-011 SHALL have ports `taken_e_i` (input, 1 bit: resolved branch condition) and `target_e_i` (input, PC_W: resolved target).
REQ-012 SHALL have ports `redirect_o` (output, 1 bit) and `redirect_pc_o` (output, PC_W): fetch redirect on mispredict.
REQ-013 SHALL have port `flush_o`, output, 1 bit: kill the D and E stages.
REQ-014 SHALL have ports `btb_wr_o` (output, 1 bit), `btb_wr_j_o` and `btb_wr_b_o` (output, 1 bit each), and `btb_wdata_o` (output, PC_W): BTB allocate request.
REQ-015 SHALL have ports `pht_update_o` and `pht_inc_o`, output, 1 bit each: predictor training strobe and direction (1 = increment).
REQ-016 SHALL have ports `branch_cnt_o` and `mispred_cnt_o`, output, 32 bits each: performance counters.

Function
REQ-017 SHALL carry {valid, pc, pred_taken, pred_target, btb_hit} from F to D to E in two stage registers, so the prediction is compared exactly 2 cycles after fetch.
REQ-018 SHALL hold both stage registers unchanged while `stall_i`=1 and `flush_o`=0.
REQ-019 SHALL, when `flush_o`=1, clear the D and E valid bits on the next edge regardless of `stall_i`; flush has priority over stall.
REQ-020 SHALL define `resolve` = E.valid AND (`is_branch_e_i` OR `is_jump_e_i`) AND state==IDLE.
REQ-021 SHALL define actual_taken as `is_jump_e_i` OR `taken_e_i`.
REQ-022 SHALL signal mispredict when `resolve` AND (pred_taken != actual_taken OR (actual_taken AND pred_target != `target_e_i`)).
REQ-023 SHALL also signal mispredict when E.valid AND pred_taken AND NOT (`is_branch_e_i` OR `is_jump_e_i`) (alias hit); the redirect target is then pc+4.
REQ-024 SHALL drive `redirect_o`=`flush_o`=mispredict combinationally in E, with `redirect_pc_o` = actual_taken ? `target_e_i` : pc+4, where the +4 wraps modulo 2^PC_W.
REQ-025 SHALL assert `btb_wr_o` when `resolve` AND NOT btb_hit AND (`is_jump_e_i` OR `taken_e_i`), with `btb_wdata_o`=`target_e_i`, `btb_wr_j_o`=`is_jump_e_i` and `btb_wr_b_o`=`is_branch_e_i`.
REQ-026 SHALL assert `pht_update_o` when `resolve` AND `is_branch_e_i`, with `pht_inc_o`=`taken_e_i`.
REQ-027 SHALL implement the recovery state machine:
- IDLE -> RECOVER on mispredict;
- RECOVER -> IDLE unconditionally after 1 cycle;
- in RECOVER, `resolve`, all update strobes and mispredict detection are masked.
REQ-028 SHALL NOT raise any output while E.valid=0; all strobes are single-cycle per resolved instruction, and a stalled E with `stall_i`=1 strobes only in its first cycle.

Reset
REQ-029 SHALL, while `reset_i`=1, clear all stage registers, set state=IDLE and clear both counters; all outputs read 0.
REQ-030 SHALL treat a reset mid-recovery or mid-stall identically: no strobe is emitted after deassertion until a new valid instruction reaches E.

Configuration
REQ-031 SHALL, with `BRU_PERF_EN` defined, increment `branch_cnt_o` on each `resolve` and `mispred_cnt_o` on each mispredict, both wrapping at 2^32.
REQ-032 SHALL, without `BRU_PERF_EN`, tie both counter outputs to 0 and synthesize no counter flops.

Structure
REQ-033 SHALL place the state enum {IDLE, RECOVER}, the constant `PC_INC`=4 and the stage-register struct type in the shared package `bru_pkg`.
REQ-034 SHALL implement each stage register as an instance of one sub-module, `bru_stage_reg`, with inputs stall, flush, d and output q.

Verification
REQ-035 SHALL cover: branch at 0x100, predicted not-taken, resolves taken to 0x200 -> `redirect_o`=1, `redirect_pc_o`=0x200, `btb_wr_o`=1, `btb_wr_b_o`=1, `pht_inc_o`=1.
REQ-036 SHALL cover: branch at 0x100, predicted taken to 0x200, resolves not-taken -> `redirect_pc_o`=0x104, `pht_update_o`=1, `pht_inc_o`=0, `btb_wr_o`=0.
REQ-037 SHALL cover: jump hits the BTB with the correct target -> no redirect, no BTB write; the next cycle's branch resolves normally.
REQ-038 SHALL cover: mispredict followed by a valid branch in E in the next cycle -> masked (RECOVER), no strobes, `mispred_cnt_o` increments by exactly 1.
REQ-039 SHALL cover: `stall_i`=1 for 3 cycles with a branch in E -> exactly one `pht_update_o` pulse; flush during the stall clears D/E.
REQ-040 SHALL cover: pc=0xFFFFFFFC, predicted taken, resolves not-taken -> `redirect_pc_o`=0x00000000; `reset_i` asserted mid-RECOVER -> all outputs 0.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;

   // Recovery state machine encoding.
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RECOVER = 1'b1
   } bru_state_e;

   // Sequential fetch increment.
   localparam int unsigned PC_INC = 4;

   // Per-stage control flags. valid sits at bit 0 so the stage register can
   // clear it without knowing the PC width carried alongside.
   typedef struct packed {
      logic pred_taken;
      logic btb_hit;
      logic valid;
   } bru_stage_t;

   localparam int unsigned BRU_VALID_BIT = 0;

endpackage

// File: rtl/bru_stage_reg.sv
// One pipeline stage register (F->D or D->E) with stall hold and flush kill.
module bru_stage_reg
   import bru_pkg::*;
#(
   parameter int unsigned W         = 8,
   parameter int unsigned VALID_BIT = BRU_VALID_BIT
) (
   input  logic         clk,
   input  logic         reset_i,
   input  logic         stall,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Flush wins over stall; only the valid bit matters when killed.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         q <= '0;
      end else if (flush) begin
         q            <= d;
         q[VALID_BIT] <= 1'b0;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries fetch predictions to E, detects mispredicts,
// drives redirect/flush, BTB allocate and PHT training strobes.
// Optional performance counters are enabled by defining BRU_PERF_EN.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int unsigned PC_W = 32
) (
   input  logic            clk,
   input  logic            reset_i,
   input  logic            valid_f_i,
   input  logic [PC_W-1:0] pc_f_i,
   input  logic            pred_taken_f_i,
   input  logic [PC_W-1:0] pred_target_f_i,
   input  logic            btb_hit_f_i,
   input  logic            stall_i,
   input  logic            is_branch_e_i,
   input  logic            is_jump_e_i,
   input  logic            taken_e_i,
   input  logic [PC_W-1:0] target_e_i,
   output logic            redirect_o,
   output logic [PC_W-1:0] redirect_pc_o,
   output logic            flush_o,
   output logic            btb_wr_o,
   output logic            btb_wr_j_o,
   output logic            btb_wr_b_o,
   output logic [PC_W-1:0] btb_wdata_o,
   output logic            pht_update_o,
   output logic            pht_inc_o,
   output logic [31:0]     branch_cnt_o,
   output logic [31:0]     mispred_cnt_o
);

   localparam int unsigned SW = 2 * PC_W + $bits(bru_stage_t);

   bru_stage_t      f_flags;
   bru_stage_t      e_flags;
   logic [SW-1:0]   f_vec;
   logic [SW-1:0]   d_vec;
   logic [SW-1:0]   e_vec;
   logic [PC_W-1:0] e_pc;
   logic [PC_W-1:0] e_pred_target;
   logic [PC_W-1:0] e_pc_next;

   bru_state_e      state_q;
   bru_state_e      state_d;
   logic            e_done_q;

   logic            e_live;
   logic            is_cti;
   logic            actual_taken;
   logic            idle;
   logic            resolve;
   logic            mispredict;
   logic            btb_wr;
   logic            pht_update;

   assign f_flags = '{pred_taken: pred_taken_f_i, btb_hit: btb_hit_f_i, valid: valid_f_i};
   assign f_vec   = {pc_f_i, pred_target_f_i, f_flags};

   bru_stage_reg #(.W(SW), .VALID_BIT(BRU_VALID_BIT)) u_stage_d (
      .clk     (clk),
      .reset_i (reset_i),
      .stall   (stall_i),
      .flush   (flush_o),
      .d       (f_vec),
      .q       (d_vec)
   );

   bru_stage_reg #(.W(SW), .VALID_BIT(BRU_VALID_BIT)) u_stage_e (
      .clk     (clk),
      .reset_i (reset_i),
      .stall   (stall_i),
      .flush   (flush_o),
      .d       (d_vec),
      .q       (e_vec)
   );

   assign {e_pc, e_pred_target, e_flags} = e_vec;

   // An instruction held in E by a stall has already strobed once; e_done_q
   // suppresses repeats until E advances or is flushed.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         e_done_q <= 1'b0;
      end else if (flush_o || !stall_i) begin
         e_done_q <= 1'b0;
      end else if (e_flags.valid) begin
         e_done_q <= 1'b1;
      end
   end

   // Resolution, mispredict detection and strobe generation in E.
   always_comb begin
      e_live       = e_flags.valid & ~e_done_q;
      is_cti       = is_branch_e_i | is_jump_e_i;
      actual_taken = is_jump_e_i | taken_e_i;
      idle         = (state_q == IDLE);
      resolve      = e_live & is_cti & idle;
      e_pc_next    = e_pc + PC_W'(PC_INC);
      mispredict   = (resolve & ((e_flags.pred_taken != actual_taken) |
                                 (actual_taken & (e_pred_target != target_e_i))))
                   | (e_live & idle & e_flags.pred_taken & ~is_cti);
      btb_wr       = resolve & ~e_flags.btb_hit & actual_taken;
      pht_update   = resolve & is_branch_e_i;
   end

   // Outputs are gated so nothing but zeros appears without a live strobe.
   always_comb begin
      redirect_o    = mispredict;
      flush_o       = mispredict;
      redirect_pc_o = '0;
      if (mispredict) begin
         redirect_pc_o = (actual_taken & is_cti) ? target_e_i : e_pc_next;
      end
      btb_wr_o      = btb_wr;
      btb_wr_j_o    = btb_wr & is_jump_e_i;
      btb_wr_b_o    = btb_wr & is_branch_e_i;
      btb_wdata_o   = btb_wr ? target_e_i : '0;
      pht_update_o  = pht_update;
      pht_inc_o     = pht_update & taken_e_i;
   end

   // Recovery FSM next state: one masked cycle after every mispredict.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mispredict) state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Recovery FSM state register.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef BRU_PERF_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] mispred_cnt_q;

   // Performance counters, wrapping at 2^32.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (resolve)    branch_cnt_q  <= branch_cnt_q + 32'd1;
         if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
`else
   assign branch_cnt_o  = '0;
   assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

   localparam int unsigned PC_W = 32;
`ifdef BRU_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_i;
   logic            valid_f_i;
   logic [PC_W-1:0] pc_f_i;
   logic            pred_taken_f_i;
   logic [PC_W-1:0] pred_target_f_i;
   logic            btb_hit_f_i;
   logic            stall_i;
   logic            is_branch_e_i;
   logic            is_jump_e_i;
   logic            taken_e_i;
   logic [PC_W-1:0] target_e_i;
   logic            redirect_o;
   logic [PC_W-1:0] redirect_pc_o;
   logic            flush_o;
   logic            btb_wr_o;
   logic            btb_wr_j_o;
   logic            btb_wr_b_o;
   logic [PC_W-1:0] btb_wdata_o;
   logic            pht_update_o;
   logic            pht_inc_o;
   logic [31:0]     branch_cnt_o;
   logic [31:0]     mispred_cnt_o;

   int          checks = 0;
   int          errors = 0;
   int unsigned exp_br = 0;
   int unsigned exp_mp = 0;
   int          pulses;

   branch_resolve_unit #(.PC_W(PC_W)) dut (
      .clk             (clk),
      .reset_i         (reset_i),
      .valid_f_i       (valid_f_i),
      .pc_f_i          (pc_f_i),
      .pred_taken_f_i  (pred_taken_f_i),
      .pred_target_f_i (pred_target_f_i),
      .btb_hit_f_i     (btb_hit_f_i),
      .stall_i         (stall_i),
      .is_branch_e_i   (is_branch_e_i),
      .is_jump_e_i     (is_jump_e_i),
      .taken_e_i       (taken_e_i),
      .target_e_i      (target_e_i),
      .redirect_o      (redirect_o),
      .redirect_pc_o   (redirect_pc_o),
      .flush_o         (flush_o),
      .btb_wr_o        (btb_wr_o),
      .btb_wr_j_o      (btb_wr_j_o),
      .btb_wr_b_o      (btb_wr_b_o),
      .btb_wdata_o     (btb_wdata_o),
      .pht_update_o    (pht_update_o),
      .pht_inc_o       (pht_inc_o),
      .branch_cnt_o    (branch_cnt_o),
      .mispred_cnt_o   (mispred_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic rd, input logic [31:0] rpc,
                          input logic wr, input logic wj, input logic wb, input logic [31:0] wd,
                          input logic pu, input logic pi);
      chk({tag, ".redirect"},    32'(redirect_o),   32'(rd));
      chk({tag, ".flush"},       32'(flush_o),      32'(rd));
      chk({tag, ".redirect_pc"}, redirect_pc_o,     rpc);
      chk({tag, ".btb_wr"},      32'(btb_wr_o),     32'(wr));
      chk({tag, ".btb_wr_j"},    32'(btb_wr_j_o),   32'(wj));
      chk({tag, ".btb_wr_b"},    32'(btb_wr_b_o),   32'(wb));
      chk({tag, ".btb_wdata"},   btb_wdata_o,       wd);
      chk({tag, ".pht_update"},  32'(pht_update_o), 32'(pu));
      chk({tag, ".pht_inc"},     32'(pht_inc_o),    32'(pi));
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, ".branch_cnt"},  branch_cnt_o,  PERF ? exp_br : 32'd0);
      chk({tag, ".mispred_cnt"}, mispred_cnt_o, PERF ? exp_mp : 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic v, input logic [31:0] pc, input logic pt,
                        input logic [31:0] tgt, input logic hit);
      valid_f_i       = v;
      pc_f_i          = pc;
      pred_taken_f_i  = pt;
      pred_target_f_i = tgt;
      btb_hit_f_i     = hit;
   endtask

   task automatic exec(input logic br, input logic j, input logic tk, input logic [31:0] tgt);
      is_branch_e_i = br;
      is_jump_e_i   = j;
      taken_e_i     = tk;
      target_e_i    = tgt;
   endtask

   initial begin
      reset_i = 1'b1;
      stall_i = 1'b0;
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exec(1'b0, 1'b0, 1'b0, 32'h0);

      // Reset state
      #12;
      chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cnt("reset");
      reset_i = 1'b0;
      step();

      // Branch 0x100 predicted not-taken, resolves taken to 0x200
      fetch(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      step();
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      exec(1'b1, 1'b0, 1'b1, 32'h200);
      #1;
      chk_out("A", 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
      exp_br++; exp_mp++;
      step();
      // RECOVER cycle with a branch still presented in E: everything masked
      chk_out("A.recover", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cnt("A");
      exec(1'b0, 1'b0, 1'b0, 32'h0);
      step();

      // Branch 0x100 predicted taken to 0x200, resolves not-taken
      fetch(1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
      step();
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      exec(1'b1, 1'b0, 1'b0, 32'h200);
      #1;
      chk_out("B", 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      exp_br++; exp_mp++;
      step();
      exec(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk_cnt("B");

      // Jump hitting BTB with correct target, then a correctly predicted branch
      fetch(1'b1, 32'h300, 1'b1, 32'h400, 1'b1);
      step();
      fetch(1'b1, 32'h304, 1'b0, 32'h0, 1'b0);
      step();
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exec(1'b0, 1'b1, 1'b0, 32'h400);
      #1;
      chk_out("C.jump", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_br++;
      step();
      exec(1'b1, 1'b0, 1'b0, 32'h340);
      #1;
      chk_out("C.branch", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      exp_br++;
      exec(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk_cnt("C");

      // Predicted taken on a non-branch (alias hit): redirect to pc+4
      fetch(1'b1, 32'h900, 1'b1, 32'hA00, 1'b1);
      step();
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      #1;
      chk_out("alias", 1'b1, 32'h904, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      exp_mp++;
      step();
      step();
      chk_cnt("alias");

      // Stall for 3 cycles with a correctly predicted branch in E
      fetch(1'b1, 32'h500, 1'b1, 32'h600, 1'b1);
      step();
      fetch(1'b1, 32'h504, 1'b0, 32'h0, 1'b0);
      step();
      fetch(1'b1, 32'h508, 1'b0, 32'h0, 1'b0);
      stall_i = 1'b1;
      exec(1'b1, 1'b0, 1'b1, 32'h600);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (pht_update_o === 1'b1) pulses++;
         chk("S.redirect", 32'(redirect_o), 32'd0);
         step();
      end
      chk("S.pht_pulses", 32'(pulses), 32'd1);
      exp_br++;
      stall_i = 1'b0;
      exec(1'b0, 1'b0, 1'b0, 32'h0);
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("S.next_redirect", 32'(redirect_o), 32'd0);
      chk_cnt("S");
      step();
      step();

      // Mispredict while stalled: flush clears D and E despite the stall
      fetch(1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
      step();
      fetch(1'b1, 32'h704, 1'b1, 32'h900, 1'b1);
      step();
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      stall_i = 1'b1;
      exec(1'b1, 1'b0, 1'b1, 32'h800);
      #1;
      chk_out("F", 1'b1, 32'h800, 1'b1, 1'b0, 1'b1, 32'h800, 1'b1, 1'b1);
      exp_br++; exp_mp++;
      step();
      exec(1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("F.recover_redirect", 32'(redirect_o), 32'd0);
      stall_i = 1'b0;
      step();
      // If D had survived, its predicted-taken non-branch would redirect here
      chk_out("F.d_killed", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cnt("F");
      step();

      // PC wrap: 0xFFFFFFFC predicted taken, resolves not-taken
      fetch(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b1);
      step();
      fetch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      exec(1'b1, 1'b0, 1'b0, 32'h10);
      #1;
      chk_out("W", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step();

      // Reset asserted mid-RECOVER
      reset_i = 1'b1;
      #1;
      exp_br = 0; exp_mp = 0;
      chk_out("R", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cnt("R");
      #10;
      reset_i = 1'b0;
      step();
      chk_out("R.after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cnt("R.after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
